// File: rtl/axi4_lite_write_master.sv
// Single-beat AXI4-Lite write master: accepts one command, drives AW/W independently, waits for B.
// Optional per-transaction abort timer enabled by defining AXI_WR_TIMEOUT_EN.
module axi4_lite_write_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [3:0]            cmd_strb,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] AW_ADDR,
    output logic                  AW_VALID,
    input  logic                  AW_READY,
    output logic [DATA_WIDTH-1:0] W_DATA,
    output logic [3:0]            WSTRB,
    output logic                  W_VALID,
    input  logic                  W_READY,
    input  logic [1:0]            B_RESP,
    input  logic                  B_VALID,
    output logic                  B_READY
);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t     state_q, state_d;
    logic       aw_valid_d, w_valid_d, done_d, load;
    logic [1:0] done_resp_d;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign B_READY   = (state_q == RESP);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        aw_valid_d  = AW_VALID;
        w_valid_d   = W_VALID;
        done_d      = 1'b0;
        done_resp_d = done_resp;
        load        = 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load       = 1'b1;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = SEND;
`ifdef AXI_WR_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            SEND: begin
                if (AW_VALID && AW_READY) aw_valid_d = 1'b0;
                if (W_VALID && W_READY)   w_valid_d  = 1'b0;
                // Both channels are finished exactly when neither VALID survives this edge.
                if (!aw_valid_d && !w_valid_d) state_d = RESP;
            end
            RESP: begin
                if (B_VALID) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    done_resp_d = B_RESP;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_WR_TIMEOUT_EN
        // Abort on the edge where the counter becomes TIMEOUT_CYCLES-1, unless B completes on it.
        if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_LAST && !done_d) begin
                state_d     = IDLE;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                done_d      = 1'b1;
                done_resp_d = 2'b10;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            AW_VALID  <= 1'b0;
            W_VALID   <= 1'b0;
            done      <= 1'b0;
            done_resp <= 2'b00;
            AW_ADDR   <= '0;
            W_DATA    <= '0;
            WSTRB     <= 4'h0;
        end else begin
            state_q   <= state_d;
            AW_VALID  <= aw_valid_d;
            W_VALID   <= w_valid_d;
            done      <= done_d;
            done_resp <= done_resp_d;
            if (load) begin
                AW_ADDR <= cmd_addr;
                W_DATA  <= cmd_data;
                WSTRB   <= cmd_strb;
            end
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Directed bench for axi4_lite_write_master; the abort-timer case runs only with AXI_WR_TIMEOUT_EN.
module tb_axi4_lite_write_master;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic        busy;
    logic        done;
    logic [1:0]  done_resp;
    logic [31:0] AW_ADDR;
    logic        AW_VALID;
    logic        AW_READY;
    logic [31:0] W_DATA;
    logic [3:0]  WSTRB;
    logic        W_VALID;
    logic        W_READY;
    logic [1:0]  B_RESP;
    logic        B_VALID;
    logic        B_READY;

    int vectors   = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int base_cnt  = 0;

    axi4_lite_write_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_strb (cmd_strb),
        .busy     (busy),
        .done     (done),
        .done_resp(done_resp),
        .AW_ADDR  (AW_ADDR),
        .AW_VALID (AW_VALID),
        .AW_READY (AW_READY),
        .W_DATA   (W_DATA),
        .WSTRB    (WSTRB),
        .W_VALID  (W_VALID),
        .W_READY  (W_READY),
        .B_RESP   (B_RESP),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts each cycle in which done was high (value seen just before the edge).
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = 2'b00;
        cyc(); cyc();

        // Reset state
        check("rst_aw_valid", AW_VALID, 0);
        check("rst_w_valid", W_VALID, 0);
        check("rst_b_ready", B_READY, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_resp", done_resp, 0);
        check("rst_aw_addr", AW_ADDR, 0);
        check("rst_w_data", W_DATA, 0);
        check("rst_wstrb", WSTRB, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        resetn = 1'b1;
        cyc();

        // Slave always ready: done three cycles after accept
        cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_data = 32'hDEADBEEF; cmd_strb = 4'hF;
        check("s1_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0;
        check("s1_aw_valid", AW_VALID, 1);
        check("s1_w_valid", W_VALID, 1);
        check("s1_aw_addr", AW_ADDR, 32'h10);
        check("s1_w_data", W_DATA, 32'hDEADBEEF);
        check("s1_wstrb", WSTRB, 4'hF);
        check("s1_busy", busy, 1);
        check("s1_cmd_ready_send", cmd_ready, 0);
        check("s1_b_ready_send", B_READY, 0);
        check("s1_done_send", done, 0);
        cyc();
        check("s1_aw_valid_resp", AW_VALID, 0);
        check("s1_w_valid_resp", W_VALID, 0);
        check("s1_b_ready_resp", B_READY, 1);
        check("s1_busy_resp", busy, 1);
        cyc();
        check("s1_done", done, 1);
        check("s1_done_resp", done_resp, 0);
        check("s1_busy_done", busy, 0);
        check("s1_b_ready_done", B_READY, 0);
        check("s1_cmd_ready_done", cmd_ready, 1);
        cyc();
        check("s1_done_pulse", done, 0);
        check("s1_done_cnt", done_cnt, 1);

        // W accepted at once, AW held off for five cycles
        base_cnt = done_cnt;
        AW_READY = 1'b0; W_READY = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 32'h24; cmd_data = 32'h12345678; cmd_strb = 4'h3;
        cyc(); cmd_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) AW_READY = 1'b1;
            check("s2_aw_valid_held", AW_VALID, 1);
            check("s2_aw_addr_stable", AW_ADDR, 32'h24);
            check("s2_w_valid", W_VALID, (i == 1) ? 1 : 0);
            check("s2_busy", busy, 1);
            cyc();
        end
        check("s2_aw_valid_dropped", AW_VALID, 0);
        check("s2_b_ready", B_READY, 1);
        cyc();
        check("s2_done", done, 1);
        check("s2_w_data", W_DATA, 32'h12345678);
        cyc();
        check("s2_single_done", done_cnt, base_cnt + 1);

        // B_VALID in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            check("idle_b_ignored", done, 0);
            cyc();
        end
        check("idle_b_done_cnt", done_cnt, base_cnt + 1);

        // B response delayed four cycles with SLVERR
        B_VALID = 1'b0; B_RESP = 2'b10;
        cmd_valid = 1'b1; cmd_addr = 32'h28; cmd_data = 32'h0BADF00D; cmd_strb = 4'h1;
        cyc(); cmd_valid = 1'b0;
        cyc();
        for (int i = 2; i <= 5; i++) begin
            check("s3_b_ready_wait", B_READY, 1);
            check("s3_busy_wait", busy, 1);
            check("s3_done_wait", done, 0);
            cyc();
        end
        B_VALID = 1'b1;
        check("s3_busy_last", busy, 1);
        cyc();
        check("s3_done", done, 1);
        check("s3_done_resp", done_resp, 2'b10);
        check("s3_busy_done", busy, 0);
        cyc();
        check("s3_done_pulse", done, 0);
        check("s3_done_resp_hold", done_resp, 2'b10);

        // Reset mid-SEND abandons the transaction
        AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_data = 32'h55AA55AA; cmd_strb = 4'hC;
        cyc(); cmd_valid = 1'b0;
        check("s4_aw_valid_pre", AW_VALID, 1);
        cyc();
        base_cnt = done_cnt;
        resetn = 1'b0;
        #1;
        check("s4_aw_valid", AW_VALID, 0);
        check("s4_w_valid", W_VALID, 0);
        check("s4_b_ready", B_READY, 0);
        check("s4_busy", busy, 0);
        check("s4_done", done, 0);
        check("s4_done_resp", done_resp, 0);
        check("s4_aw_addr", AW_ADDR, 0);
        check("s4_w_data", W_DATA, 0);
        check("s4_wstrb", WSTRB, 0);
        cyc(); cyc();
        resetn = 1'b1;
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = 2'b01;
        cyc();
        check("s4_no_done", done_cnt, base_cnt);
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_data = 32'hCAFEF00D; cmd_strb = 4'h5;
        cyc(); cmd_valid = 1'b0;
        check("s4_aw_addr_next", AW_ADDR, 32'h40);
        check("s4_w_data_next", W_DATA, 32'hCAFEF00D);
        check("s4_wstrb_next", WSTRB, 4'h5);
        cyc(); cyc();
        check("s4_done_next", done, 1);
        check("s4_done_resp_next", done_resp, 2'b01);
        cyc();
        check("s4_done_cnt", done_cnt, base_cnt + 1);

        // Back-to-back commands with cmd_valid held high
        base_cnt = done_cnt;
        B_RESP = 2'b00;
        cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_data = 32'h11111111; cmd_strb = 4'hF;
        cyc();
        cmd_addr = 32'h54; cmd_data = 32'h22222222; cmd_strb = 4'hA;
        check("s5_aw_addr_a", AW_ADDR, 32'h50);
        check("s5_w_data_a", W_DATA, 32'h11111111);
        check("s5_cmd_ready_busy", cmd_ready, 0);
        cyc();
        check("s5_b_ready_a", B_READY, 1);
        cyc();
        check("s5_done_a", done, 1);
        check("s5_cmd_ready_done", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0;
        check("s5_aw_valid_b", AW_VALID, 1);
        check("s5_aw_addr_b", AW_ADDR, 32'h54);
        check("s5_w_data_b", W_DATA, 32'h22222222);
        check("s5_wstrb_b", WSTRB, 4'hA);
        check("s5_busy_b", busy, 1);
        cyc(); cyc();
        check("s5_done_b", done, 1);
        cyc();
        check("s5_done_cnt", done_cnt, base_cnt + 2);

`ifdef AXI_WR_TIMEOUT_EN
        // AW never accepted: abort with SLVERR eight cycles after accept
        AW_READY = 1'b0; W_READY = 1'b1; B_VALID = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 32'h60; cmd_data = 32'h60606060; cmd_strb = 4'hF;
        cyc(); cmd_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            check("to_done_wait", done, 0);
            check("to_busy_wait", busy, 1);
            check("to_aw_valid_wait", AW_VALID, 1);
            cyc();
        end
        check("to_done", done, 1);
        check("to_done_resp", done_resp, 2'b10);
        check("to_aw_valid", AW_VALID, 0);
        check("to_w_valid", W_VALID, 0);
        check("to_b_ready", B_READY, 0);
        check("to_busy", busy, 0);
        cyc();
        check("to_aw_valid_after", AW_VALID, 0);
        check("to_done_pulse", done, 0);
        AW_READY = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_write_master.md
AXI4_LITE_WRITE_MASTER -- requirements
Module: axi4_lite_write_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the abort limit in clock cycles per transaction (used only when AXI_WR_TIMEOUT_EN is defined).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port cmd_valid, input, 1 bit: the user presents a write command.
REQ-007 Port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-008 Port cmd_addr, input, ADDR_WIDTH bits: the command address.
REQ-009 Port cmd_data, input, DATA_WIDTH bits: the command data.
REQ-010 Port cmd_strb, input, 4 bits: the command byte strobes.
REQ-011 Port busy, output, 1 bit: a transaction is in flight.
REQ-012 Port done, output, 1 bit: a one-cycle completion pulse.
REQ-013 Port done_resp, output, 2 bits: the completion response, valid when done=1.
REQ-014 Ports AW_ADDR (output, ADDR_WIDTH), AW_VALID (output, 1), AW_READY (input, 1): the AXI4-Lite write-address channel.
REQ-015 Ports W_DATA (output, DATA_WIDTH), WSTRB (output, 4), W_VALID (output, 1), W_READY (input, 1): the AXI4-Lite write-data channel.
REQ-016 Ports B_RESP (input, 2), B_VALID (input, 1), B_READY (output, 1): the AXI4-Lite write-response channel.

Function
REQ-017 The FSM SHALL have three states: IDLE, SEND, RESP; encoding is free.
REQ-018 cmd_ready SHALL be 1 only in IDLE, and SHALL be combinational from state.
REQ-019 In IDLE, if cmd_valid=1, the block SHALL latch cmd_addr/cmd_data/cmd_strb into AW_ADDR/W_DATA/WSTRB and go to SEND; AW_VALID and W_VALID SHALL be 1 on the next cycle.
REQ-020 In SEND, AW_VALID SHALL stay 1 until the first cycle with AW_VALID&&AW_READY, then drop to 0 on the next cycle; W_VALID SHALL behave the same against W_READY, independently.
REQ-021 The block SHALL accept AW before W, W before AW, or both in the same cycle, with no ordering dependency.
REQ-022 AW_ADDR, W_DATA and WSTRB SHALL stay stable while their VALID is 1.
REQ-023 SEND SHALL go to RESP on the cycle when both handshakes have completed (including the current one).
REQ-024 B_READY SHALL be 1 throughout RESP and 0 in all other states.
REQ-025 On B_VALID&&B_READY in RESP, the block SHALL return to IDLE, pulse done=1 for exactly one cycle, and set done_resp=B_RESP; done_resp SHALL hold its value until the next completion.
REQ-026 busy SHALL be 1 in SEND and RESP.
REQ-027 The minimum command-to-done latency SHALL be 3 cycles when the slave is always ready; the next command SHALL be acceptable in the cycle done is high.
REQ-028 B_VALID outside RESP SHALL be ignored.

Reset
REQ-029 While resetn=0, the block SHALL enter IDLE asynchronously with all outputs 0: AW_VALID, W_VALID, B_READY, done, busy, done_resp, AW_ADDR, W_DATA, WSTRB, and the timeout counter.
REQ-030 A reset asserted mid-transaction SHALL abandon the transaction without a done pulse.

Configuration
REQ-031 When the macro AXI_WR_TIMEOUT_EN is defined, a counter SHALL clear on command accept and increment each cycle in SEND/RESP.
REQ-032 When that counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL drop all VALID/READY outputs, return to IDLE, and pulse done with done_resp=2'b10.
REQ-033 When AXI_WR_TIMEOUT_EN is undefined, the block SHALL contain no counter and SHALL wait indefinitely; TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-034 Scenario: cmd addr=0x10, data=0xDEADBEEF, strb=0xF, with AW_READY/W_READY/B_VALID tied 1 -> AW/W handshake at cycle 1, done at cycle 3, done_resp=0.
REQ-035 Scenario: W_READY=1 immediately, AW_READY delayed 5 cycles -> W_VALID drops after 1 cycle, AW_VALID held 6 cycles, AW_ADDR stable, single done.
REQ-036 Scenario: B_VALID=1 with B_RESP=2'b10 delayed 4 cycles in RESP -> done_resp=2'b10, busy=1 until done.
REQ-037 Scenario: resetn pulsed low during SEND -> all outputs 0 immediately, no done; the next command completes normally.
REQ-038 Scenario: AXI_WR_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, AW_READY held 0 -> done with done_resp=2'b10 at 8 cycles after accept, AW_VALID=0 after.
REQ-039 Scenario: back-to-back commands with cmd_valid held 1 -> second command accepted in the IDLE cycle after done, and no transaction is dropped.
